// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product compute stage.
// Imported by the engine, its MAC datapath and the memory interface users.
package dp_pkg;

  localparam int MAX_LEN_DEF = 1024;
  localparam int ACC_W_DEF   = 64;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_VEC_A  = 8'h08;
  localparam logic [7:0] REG_VEC_B  = 8'h0C;
  localparam logic [7:0] REG_LEN    = 8'h10;
  localparam logic [7:0] REG_OUT    = 8'h14;

  typedef enum logic [1:0] {
    STAT_INVALID = 2'd0,
    STAT_BUSY    = 2'd1,
    STAT_ERROR   = 2'd2,
    STAT_DONE    = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    WT_A,
    RD_B,
    WT_B,
    MAC,
    WR_LO,
    WT_LO,
    WR_HI,
    WT_HI,
    DONE,
    ERROR
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// Single-outstanding memory request/response port of the engine.
// master = engine side, slave = memory side.
interface dot_product_engine_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_rdata,
    input  mem_rsp_err
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_rdata,
    output mem_rsp_err
  );

endinterface

// File: rtl/dp_mac.sv
// Registered signed 32x32 multiply with wrapping accumulate.
// clr has priority over en; the product is a full-width signed result.
module dp_mac
  import dp_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] prod;

  // low ACC_W bits of the extended product equal the signed product
  assign a_ext = {{(ACC_W-32){a_i[31]}}, a_i};
  assign b_ext = {{(ACC_W-32){b_i[31]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_engine.sv
// Fetches two signed vectors, multiply-accumulates them and writes
// the 64-bit result back; pulses busy/done/error for the register block.
module dot_product_engine
  import dp_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [31:0]                 ctrl_reg,
  input  logic [31:0]                 vec_a_addr,
  input  logic [31:0]                 vec_b_addr,
  input  logic [31:0]                 vec_len,
  input  logic [31:0]                 out_addr,
  dot_product_engine_if.master        mem,
  output logic                        set_busy,
  output logic                        set_done,
  output logic                        set_error
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e           state_q;
  logic             start_q;
  logic [31:0]      a_ptr_q;
  logic [31:0]      b_ptr_q;
  logic [31:0]      out_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;
  logic [LW-1:0]    idx_d;
  logic [31:0]      a_el_q;
  logic [31:0]      b_el_q;
  logic             req_valid_q;
  logic             req_we_q;
  logic [31:0]      req_addr_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [ACC_W-1:0] acc;

  logic start;
  logic bad_cfg;
  logic hs;
  logic rsp_ok;
  logic rsp_bad;
  logic mac_clr;
  logic mac_en;
  logic unused_ctrl;

  assign unused_ctrl = ^ctrl_reg[31:1];

  assign start   = ctrl_reg[0] & ~start_q;
  assign bad_cfg = (vec_len == 32'd0)
                 | (vec_len > 32'(MAX_LEN))
                 | misaligned(vec_a_addr[1:0])
                 | misaligned(vec_b_addr[1:0])
                 | misaligned(out_addr[1:0]);

  assign hs      = req_valid_q & mem.mem_req_ready;
  assign rsp_ok  = mem.mem_rsp_valid & ~mem.mem_rsp_err;
  assign rsp_bad = mem.mem_rsp_valid & mem.mem_rsp_err;
  assign idx_d   = idx_q + 1'b1;

  assign mac_clr = (state_q == IDLE) & start & ~bad_cfg;
  assign mac_en  = (state_q == MAC);

  dp_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_el_q),
    .b_i   (b_el_q),
    .acc_o (acc)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      out_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      a_el_q      <= '0;
      b_el_q      <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= ctrl_reg[0];
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (hs) begin
        req_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (start && bad_cfg) begin
            state_q <= ERROR;
          end else if (start) begin
            a_ptr_q     <= vec_a_addr;
            b_ptr_q     <= vec_b_addr;
            out_q       <= out_addr;
            len_q       <= vec_len[LW-1:0];
            idx_q       <= '0;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b0;
            req_addr_q  <= vec_a_addr;
            state_q     <= RD_A;
          end
        end
        RD_A: if (hs) state_q <= WT_A;
        WT_A: begin
          if (rsp_bad) begin
            state_q <= ERROR;
          end else if (rsp_ok) begin
            a_el_q      <= mem.mem_rsp_rdata;
            req_valid_q <= 1'b1;
            req_addr_q  <= b_ptr_q;
            state_q     <= RD_B;
          end
        end
        RD_B: if (hs) state_q <= WT_B;
        WT_B: begin
          if (rsp_bad) begin
            state_q <= ERROR;
          end else if (rsp_ok) begin
            b_el_q  <= mem.mem_rsp_rdata;
            state_q <= MAC;
          end
        end
        MAC: begin
          a_ptr_q     <= a_ptr_q + 32'd4;
          b_ptr_q     <= b_ptr_q + 32'd4;
          idx_q       <= idx_d;
          req_valid_q <= 1'b1;
          if (idx_d == len_q) begin
            req_we_q   <= 1'b1;
            req_addr_q <= out_q;
            state_q    <= WR_LO;
          end else begin
            req_addr_q <= a_ptr_q + 32'd4;
            state_q    <= RD_A;
          end
        end
        WR_LO: if (hs) state_q <= WT_LO;
        WT_LO: begin
          if (rsp_bad) begin
            state_q <= ERROR;
          end else if (rsp_ok) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= out_q + 32'd4;
            state_q     <= WR_HI;
          end
        end
        WR_HI: if (hs) state_q <= WT_HI;
        WT_HI: begin
          if (rsp_bad) begin
            state_q <= ERROR;
          end else if (rsp_ok) begin
            req_we_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        ERROR: begin
          req_we_q <= 1'b0;
          err_q    <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // accumulator is frozen during both writes, so wdata is stable
  assign mem.mem_req_wdata = (state_q == WR_HI) ? acc[ACC_W-1:32]
                                                : acc[31:0];
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign set_busy          = busy_q;
  assign set_done          = done_q;
  assign set_error         = err_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench: memory model with backpressure, write scoreboard,
// pulse monitor and latency/reset/error scenarios.
module tb_dot_product_engine;
  import dp_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl;
  logic [31:0] a_addr;
  logic [31:0] b_addr;
  logic [31:0] len;
  logic [31:0] o_addr;
  logic        busy;
  logic        done;
  logic        err;

  dot_product_engine_if mem();

  dot_product_engine dut (
    .ACLK       (clk),
    .ARESETn    (rst_n),
    .ctrl_reg   (ctrl),
    .vec_a_addr (a_addr),
    .vec_b_addr (b_addr),
    .vec_len    (len),
    .out_addr   (o_addr),
    .mem        (mem),
    .set_busy   (busy),
    .set_done   (done),
    .set_error  (err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  logic [31:0] mem_arr [logic [31:0]];
  wr_t exp_q[$];

  int ready_dly = 0;
  int rsp_dly = 0;
  int err_read_n = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int req_total = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int start_cyc = 0;
  int busy_cyc = -1;
  int done_cyc = -1;
  int req0 = 0;
  int wr0 = 0;

  bit          pend = 0;
  int          rsp_cnt = 0;
  logic [31:0] p_rdata = '0;
  bit          p_err = 0;
  int          wait_cnt = 0;
  bit          waiting = 0;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      busy_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
    if (busy | done | err)
      chk("pulse_excl", 64'(busy) + 64'(done) + 64'(err), 64'd1);
  end

  // memory slave: everything changes on the falling edge
  always @(negedge clk) begin
    wr_t e;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_err   = 1'b0;
    if (pend) begin
      if (rsp_cnt == 0) begin
        mem.mem_rsp_valid = 1'b1;
        mem.mem_rsp_rdata = p_rdata;
        mem.mem_rsp_err   = p_err;
        pend = 0;
      end else begin
        rsp_cnt--;
      end
    end
    mem.mem_req_ready = 1'b0;
    if (!mem.mem_req_valid) begin
      waiting  = 0;
      wait_cnt = 0;
    end else if (!pend && !mem.mem_rsp_valid) begin
      if (waiting) begin
        chk("stable_addr", mem.mem_req_addr, w_addr);
        chk("stable_we", mem.mem_req_we, w_we);
        chk("stable_wdata", mem.mem_req_wdata, w_wdata);
      end
      if (wait_cnt >= ready_dly) begin
        mem.mem_req_ready = 1'b1;
        wait_cnt = 0;
        waiting  = 0;
        pend     = 1;
        rsp_cnt  = rsp_dly;
        req_total++;
        if (mem.mem_req_we) begin
          wr_cnt++;
          p_err = 0;
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", mem.mem_req_addr, 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", mem.mem_req_addr, e.addr);
            chk("wr_data", mem.mem_req_wdata, e.data);
          end
        end else begin
          rd_cnt++;
          p_rdata = mem_arr.exists(mem.mem_req_addr) ?
                    mem_arr[mem.mem_req_addr] : 32'h0;
          p_err = (rd_cnt == err_read_n);
        end
      end else begin
        if (!waiting) begin
          w_addr  = mem.mem_req_addr;
          w_we    = mem.mem_req_we;
          w_wdata = mem.mem_req_wdata;
        end
        waiting = 1;
        wait_cnt++;
      end
    end
  end

  task automatic push_exp(input logic [31:0] o, input logic [63:0] r);
    wr_t e;
    e.addr = o;
    e.data = r[31:0];
    exp_q.push_back(e);
    e.addr = o + 32'd4;
    e.data = r[63:32];
    exp_q.push_back(e);
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] n, input logic [31:0] o);
    @(negedge clk);
    a_addr = a;
    b_addr = b;
    len    = n;
    o_addr = o;
    ctrl   = 32'd0;
    @(negedge clk);
    ctrl = 32'd1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    busy_cnt  = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    busy_cyc  = -1;
    done_cyc  = -1;
    req0      = req_total;
    wr0       = wr_cnt;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (done_cnt + err_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ended"}, 64'(done_cnt + err_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_ok(input string tag);
    chk({tag, "_busy"}, 64'(busy_cnt), 64'd1);
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err"}, 64'(err_cnt), 64'd0);
    chk({tag, "_writes"}, 64'(wr_cnt - wr0), 64'd2);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_bad(input string tag, input int exp_busy,
                           input int exp_reqs);
    chk({tag, "_err"}, 64'(err_cnt), 64'd1);
    chk({tag, "_done"}, 64'(done_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(exp_busy));
    chk({tag, "_writes"}, 64'(wr_cnt - wr0), 64'd0);
    if (exp_reqs >= 0)
      chk({tag, "_reqs"}, 64'(req_total - req0), 64'(exp_reqs));
    chk({tag, "_idle"}, 64'(mem.mem_req_valid), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 64'(mem.mem_req_valid), 64'd0);
    chk({tag, "_we"}, 64'(mem.mem_req_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem.mem_req_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem.mem_req_wdata), 64'd0);
    chk({tag, "_flags"}, 64'({busy, done, err}), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ctrl   = '0;
    a_addr = '0;
    b_addr = '0;
    len    = '0;
    o_addr = '0;
    for (int i = 0; i < 4; i++) begin
      mem_arr[32'h100 + 32'(4 * i)] = 32'(i + 1);
      mem_arr[32'h200 + 32'(4 * i)] = 32'(i + 5);
    end
    for (int i = 0; i < 2; i++) begin
      mem_arr[32'h400 + 32'(4 * i)] = 32'h8000_0000;
      mem_arr[32'h500 + 32'(4 * i)] = 32'h8000_0000;
    end
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    push_exp(32'h300, 64'd70);
    start_job(32'h100, 32'h200, 32'd4, 32'h300);
    wait_end("basic", 200);
    check_ok("basic");
    chk("basic_busy_cyc", 64'(busy_cyc - start_cyc), 64'd0);
    chk("basic_latency", 64'(done_cyc - start_cyc), 64'd25);
    chk("basic_reads", 64'(req_total - req0), 64'd10);

    push_exp(32'h600, 64'h8000_0000_0000_0000);
    start_job(32'h400, 32'h500, 32'd2, 32'h600);
    wait_end("signed", 200);
    check_ok("signed");
    chk("signed_latency", 64'(done_cyc - start_cyc), 64'd15);

    start_job(32'h100, 32'h200, 32'd0, 32'h300);
    wait_end("len0", 50);
    check_bad("len0", 0, 0);
    start_job(32'h100, 32'h1002, 32'd4, 32'h300);
    wait_end("misalign", 50);
    check_bad("misalign", 0, 0);
    start_job(32'h100, 32'h200, 32'd1025, 32'h300);
    wait_end("len1025", 50);
    check_bad("len1025", 0, 0);

    ready_dly = 3;
    rsp_dly   = 2;
    push_exp(32'h700, 64'd70);
    start_job(32'h100, 32'h200, 32'd4, 32'h700);
    wait_end("bp", 600);
    check_ok("bp");
    ready_dly = 0;
    rsp_dly   = 0;

    err_read_n = rd_cnt + 3;
    start_job(32'h100, 32'h200, 32'd4, 32'hB00);
    wait_end("rsperr", 200);
    check_bad("rsperr", 1, 3);
    err_read_n = 0;
    push_exp(32'hB00, 64'd70);
    start_job(32'h100, 32'h200, 32'd4, 32'hB00);
    wait_end("after_err", 200);
    check_ok("after_err");

    push_exp(32'hA00, 64'd70);
    start_job(32'h100, 32'h200, 32'd4, 32'hA00);
    repeat (6) @(negedge clk);
    ctrl   = 32'd0;
    a_addr = 32'h1234_5670;
    len    = 32'd7;
    o_addr = 32'hDEAD_0000;
    @(negedge clk);
    ctrl = 32'd1;
    wait_end("busy_restart", 200);
    check_ok("busy_restart");

    rsp_dly = 4;
    start_job(32'h100, 32'h200, 32'd4, 32'hC00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ctrl  = 32'd0;
    #1;
    chk("rst_async_valid", 64'(mem.mem_req_valid), 64'd0);
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 50 && pend; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    check_quiet("late_rsp");
    chk("late_rsp_pulses", 64'(busy_cnt + done_cnt + err_cnt), 64'd1);
    chk("late_rsp_reqs", 64'(req_total - req0), 64'd1);
    rsp_dly = 0;
    push_exp(32'hD00, 64'd70);
    start_job(32'h100, 32'h200, 32'd4, 32'hD00);
    wait_end("post_rst", 200);
    check_ok("post_rst");
    chk("post_rst_latency", 64'(done_cyc - start_cyc), 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Compute stage directly downstream of the AXI-Lite register block.
- Consumes the control, vector-A address, vector-B address, length and output-address registers.
- Fetches two signed 32-bit vectors over a single-outstanding memory request port, multiply-accumulates them, and writes a 64-bit result back to memory.
- Drives the set_busy, set_done and set_error pulses that the register block uses to update its status register and clear the control register.

Parameters:
- MAX_LEN, 1024, largest legal vector length in elements.
- ACC_W, 64, accumulator and result width in bits.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ctrl_reg  in  32  control register; bit0 = start
- vec_a_addr  in  32  byte address of vector A
- vec_b_addr  in  32  byte address of vector B
- vec_len  in  32  element count
- out_addr  in  32  byte address of the 64-bit result
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  32  request byte address
- mem_req_wdata  out  32  write data
- mem_rsp_valid  in  1  read data or write acknowledge valid; one per request
- mem_rsp_rdata  in  32  read data
- mem_rsp_err  in  1  response error, qualified by mem_rsp_valid
- set_busy  out  1  one-cycle pulse on accepted start
- set_done  out  1  one-cycle pulse on successful completion
- set_error  out  1  one-cycle pulse on failure

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; accumulator, index and start-edge register cleared.
  - Reset mid-operation aborts immediately. Any memory response arriving after reset is ignored.
- Start detection:
  - Start = ctrl_reg[0] is 1 and was 0 on the previous cycle, sampled only in IDLE.
  - Rising edges outside IDLE are ignored; the edge register still tracks the input.
  - After an error the control register is not cleared, so software must write 0 and then 1 to restart.
- Length and address checks on start (in IDLE):
  - vec_len == 0, vec_len > MAX_LEN, or any of the three addresses with bits[1:0] != 0 → go to ERROR. set_busy is not pulsed.
  - Otherwise: latch all four address/length inputs, clear accumulator and index, pulse set_busy, go to RD_A.
  - Later register changes do not affect the running job.
- State sequence:
  - RD_A: drive read at a_ptr; on mem_req_valid && mem_req_ready → WT_A.
  - WT_A: on mem_rsp_valid, capture the A element → RD_B.
  - RD_B: drive read at b_ptr; on handshake → WT_B.
  - WT_B: on mem_rsp_valid, capture the B element → MAC.
  - MAC (one cycle): acc += signed(A) × signed(B), a full 64-bit product. Pointers += 4, index += 1. If index == len → WR_LO, else → RD_A.
  - WR_LO: write acc[31:0] to out_addr; after handshake wait for the acknowledge → WR_HI.
  - WR_HI: write acc[63:32] to out_addr + 4; after the acknowledge → DONE.
  - DONE: pulse set_done for one cycle → IDLE.
  - ERROR: pulse set_error for one cycle → IDLE.
- Request handshake rules:
  - mem_req_valid is held with address, we and wdata stable until ready.
  - At most one outstanding request; no new request is issued before its response.
  - mem_rsp_valid outside a wait state is ignored.
- Response errors:
  - mem_rsp_err on any response → ERROR. The accumulator is discarded and no result write is issued.
- Arithmetic:
  - The accumulator wraps modulo 2^64 with no saturation.
  - Pointer addition wraps modulo 2^32.
- Status exclusivity: set_busy, set_done and set_error are never asserted in the same cycle.
- Latency for length N with zero-wait memory (ready = 1, response the cycle after the handshake):
  - 5 cycles per element, plus 4 cycles for the two writes, plus 1 cycle for DONE.
  - set_done asserts 5N + 5 cycles after the start edge is sampled.

Decomposition:
- Shared package dp_pkg:
  - state enum
  - register byte offsets (0x00, 0x04, 0x08, 0x0C, 0x10, 0x14)
  - status codes (INVALID = 0, BUSY = 1, ERROR = 2, DONE = 3)
  - defaults for MAX_LEN and ACC_W
- One sub-module, dp_mac:
  - registered signed 32 × 32 multiply and 64-bit accumulate
  - clear and enable inputs
  - the MAC state drives enable

Test Plan:
- Basic job: A = {1, 2, 3, 4}, B = {5, 6, 7, 8}, len = 4, zero-wait memory → set_busy pulse, then writes 70 to out_addr and 0 to out_addr + 4, then set_done exactly 25 cycles after start.
- Signed/wrap: A = {0x80000000, 0x80000000}, B = {0x80000000, 0x80000000} → result 0x8000000000000000 (lo = 0, hi = 0x80000000), no error.
- Illegal starts:
  - vec_len = 0 → set_error pulse, no memory requests, no set_busy.
  - vec_b_addr = 0x1002 → same response.
  - vec_len = 1025 → same response.
- Backpressure: mem_req_ready held low 3 cycles on each request and response delayed 2 cycles → same result as the basic job; request signals stable while waiting.
- Response error: mem_rsp_err on the third read → set_error, no write requests issued, engine returns to IDLE. A new 0→1 start edge then runs the basic job correctly.
- Restart and reset:
  - Start edge while busy → ignored.
  - ARESETn low mid-job → all outputs 0 next cycle; a late response is ignored; a following job completes normally.
